snake_engine_gen: RTL and testbench
===================================

SNAKE_ENGINE_GEN -- requirements
Module: snake_engine_gen

Interface
REQ-001 SHALL have parameter GRID_W, default 16, meaning grid columns (power of two, 4..256).
REQ-002 SHALL have parameter GRID_H, default 16, meaning grid rows (power of two, 4..256).
REQ-003 SHALL have parameter MAX_LEN, default 16, meaning maximum body segments (2..64).
REQ-004 SHALL have parameter WRAP, default 0, meaning 0 = walls are fatal and 1 = edges wrap around.
REQ-005 SHALL derive XW = clog2(GRID_W), YW = clog2(GRID_H), LW = clog2(MAX_LEN+1), SW = XW+YW.
REQ-006 SHALL have Clk, input, 1, the single clock. Reset is asynchronous and active-high.
REQ-007 SHALL have Reset, input, 1, asynchronous active-high reset.
REQ-008 SHALL have Tick, input, 1, one-cycle move strobe.
REQ-009 SHALL have Left, Right, Up and Down, inputs, 1 each, one-cycle debounced pulses.
REQ-010 SHALL have Ack, input, 1, one-cycle start/acknowledge pulse.
REQ-011 SHALL have Head_X/Head_Y, outputs, XW/YW, equal to segment 0.
REQ-012 SHALL have Food_X/Food_Y, outputs, XW/YW, the food cell.
REQ-013 SHALL have Length, output, LW, the live segment count.
REQ-014 SHALL have Locations_Flat, output, MAX_LEN*SW; segment i is at bits [i*SW +: SW] as {X,Y}; segments at or above Length are don't-care.
REQ-015 SHALL have Qi, Qm, Qc, Qe, Qw and Ql, outputs, 1 each, one-hot state flags for INIT, MOVE, CHECK, EAT, WIN and LOSE.

Function
REQ-016 SHALL implement a one-hot FSM: INIT -Ack-> MOVE; MOVE -Tick-> CHECK; CHECK -> LOSE, EAT or MOVE in 1 cycle; EAT -> MOVE or WIN; WIN/LOSE -Ack-> INIT.
REQ-017 SHALL, in INIT, hold the body at its reset value and ignore Tick.
REQ-018 SHALL keep a pending-direction register that updates on any button pulse in any state. Priority when pulses coincide: Up > Down > Left > Right.
REQ-019 SHALL discard a button that reverses the current direction when Length > 1.
REQ-020 SHALL, on Tick in MOVE, commit pending to current direction and register the candidate head (head +/- 1 on one axis). Y increases Down.
REQ-021 SHALL handle an off-grid candidate as follows: WRAP=1 wraps modulo GRID_W/GRID_H; WRAP=0 sets an out-of-bounds flag.
REQ-022 SHALL, in CHECK, set grow = (candidate == food). It SHALL go to LOSE if the out-of-bounds flag is set, or the candidate equals any segment i < Length-1 (i < Length when grow). Body state SHALL be unchanged on LOSE.
REQ-023 SHALL, in CHECK when not losing, shift seg[i] <= seg[i-1] and seg[0] <= candidate.
REQ-024 SHALL, when grow, increment Length (saturating at MAX_LEN) and go to EAT; otherwise it SHALL return to MOVE.
REQ-025 SHALL run a free-running 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1, never zero). Its low SW bits give the food candidate.
REQ-026 SHALL, in EAT, go to WIN if Length == MAX_LEN.
REQ-027 SHALL, in EAT with Length < MAX_LEN, load the LFSR candidate as food if it overlaps no live segment, then go to MOVE. On overlap it SHALL stay in EAT and retry the next cycle.
REQ-028 SHALL ignore Tick outside MOVE; it is not queued.
REQ-029 SHALL give Ack no effect in MOVE, CHECK or EAT.
REQ-030 SHALL keep latency at 1 cycle Tick-to-CHECK and 1 cycle CHECK-to-updated outputs.

Reset
REQ-031 SHALL, on Reset (asynchronous and dominant mid-operation), set state to INIT (Qi=1, other flags 0).
REQ-032 SHALL, on Reset, set Length=1, seg0=(GRID_W/2, GRID_H/2), direction and pending to Right, food to (GRID_W/2+2, GRID_H/2), and LFSR to the seed.
REQ-033 SHALL, on entry to INIT from WIN/LOSE, restore the body, Length, direction and food to the REQ-032 values; the LFSR is not reseeded.

Verification
REQ-034 SHALL cover the defaults case: Reset, Ack, Tick x2 -> head (9,8) then (10,8), Length=2 after the second CHECK, EAT exits to MOVE with food not on the body.
REQ-035 SHALL cover a wall hit: WRAP=0, Right held, Ticks until head x=15, next Tick -> Ql=1, Head_X stays 15.
REQ-036 SHALL cover wrap-around: WRAP=1, same stimulus as REQ-035 -> Head_X=0, Qm=1.
REQ-037 SHALL cover reversal and priority: Length=2 moving Right, Left pulse ignored; Up+Left in the same cycle -> next move to y-1.
REQ-038 SHALL cover self-collision and win: a 5-segment body turned Down, Left, Up -> LOSE; MAX_LEN=2 after one eat -> Qw=1, then Ack -> INIT with Length=1.
REQ-039 SHALL cover reset mid-operation: Reset asserted during EAT -> Qi=1 and all REQ-032 values within the same cycle.

Source files
------------

// File: rtl/snake_engine_gen.sv
// Snake game engine: one-hot FSM, shift-register body, LFSR food placement.
// Grid coordinates are {X,Y}; Y grows downward.
module snake_engine_gen #(
  parameter int unsigned GRID_W  = 16,
  parameter int unsigned GRID_H  = 16,
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned WRAP    = 0,
  localparam int unsigned XW = $clog2(GRID_W),
  localparam int unsigned YW = $clog2(GRID_H),
  localparam int unsigned LW = $clog2(MAX_LEN + 1),
  localparam int unsigned SW = XW + YW
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Tick,
  input  logic                  Left,
  input  logic                  Right,
  input  logic                  Up,
  input  logic                  Down,
  input  logic                  Ack,
  output logic [XW-1:0]         Head_X,
  output logic [YW-1:0]         Head_Y,
  output logic [XW-1:0]         Food_X,
  output logic [YW-1:0]         Food_Y,
  output logic [LW-1:0]         Length,
  output logic [MAX_LEN*SW-1:0] Locations_Flat,
  output logic                  Qi,
  output logic                  Qm,
  output logic                  Qc,
  output logic                  Qe,
  output logic                  Qw,
  output logic                  Ql
);

  typedef enum logic [5:0] {
    S_INIT  = 6'b000001,
    S_MOVE  = 6'b000010,
    S_CHECK = 6'b000100,
    S_EAT   = 6'b001000,
    S_WIN   = 6'b010000,
    S_LOSE  = 6'b100000
  } state_t;

  // Encoding chosen so that XOR with 1 gives the opposite direction.
  typedef enum logic [1:0] {DIR_R = 2'd0, DIR_L = 2'd1, DIR_U = 2'd2, DIR_D = 2'd3} dir_t;

  localparam logic [XW-1:0] HOME_X  = XW'(GRID_W / 2);
  localparam logic [YW-1:0] HOME_Y  = YW'(GRID_H / 2);
  localparam logic [XW-1:0] FOOD_X0 = XW'(GRID_W / 2 + 2);
  localparam logic [SW-1:0] HOME    = {HOME_X, HOME_Y};
  localparam logic [15:0]   SEED    = 16'hACE1;

  state_t        state, state_n;
  dir_t          dir, pend;
  logic [SW-1:0] seg [MAX_LEN];
  logic [LW-1:0] len;
  logic [XW-1:0] food_x, cand_x;
  logic [YW-1:0] food_y, cand_y;
  logic          oob;
  logic [15:0]   lfsr;

  logic [XW-1:0] head_x_c, next_x_c;
  logic [YW-1:0] head_y_c, next_y_c;
  logic          next_oob_c;
  dir_t          btn_dir_c;
  logic          btn_valid_c;
  logic [1:0]    rev_c;
  logic          grow_c, hit_c, lose_c, food_hit_c, win_c, lfsr_fb_c;
  logic [LW-1:0] limit_c;

  assign head_x_c  = seg[0][SW-1:YW];
  assign head_y_c  = seg[0][YW-1:0];
  assign lfsr_fb_c = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign win_c     = (len == LW'(MAX_LEN));

  // Button decode: fixed priority, then drop a reversal of a multi-segment body.
  always_comb begin
    btn_valid_c = 1'b1;
    btn_dir_c   = DIR_R;
    rev_c       = dir ^ 2'b01;
    if (Up)         btn_dir_c = DIR_U;
    else if (Down)  btn_dir_c = DIR_D;
    else if (Left)  btn_dir_c = DIR_L;
    else if (Right) btn_dir_c = DIR_R;
    else            btn_valid_c = 1'b0;
    if (len > LW'(1) && btn_dir_c == dir_t'(rev_c)) btn_valid_c = 1'b0;
  end

  // Candidate head from the pending direction; power-of-two grid wraps naturally.
  always_comb begin
    next_x_c   = head_x_c;
    next_y_c   = head_y_c;
    next_oob_c = 1'b0;
    case (pend)
      DIR_R: begin next_x_c = head_x_c + XW'(1); next_oob_c = (head_x_c == XW'(GRID_W - 1)); end
      DIR_L: begin next_x_c = head_x_c - XW'(1); next_oob_c = (head_x_c == '0); end
      DIR_U: begin next_y_c = head_y_c - YW'(1); next_oob_c = (head_y_c == '0); end
      default: begin next_y_c = head_y_c + YW'(1); next_oob_c = (head_y_c == YW'(GRID_H - 1)); end
    endcase
    if (WRAP != 0) next_oob_c = 1'b0;
  end

  // Collision against the body; the tail is exempt unless the snake grows this move.
  always_comb begin
    grow_c     = ({cand_x, cand_y} == {food_x, food_y});
    limit_c    = grow_c ? len : len - LW'(1);
    hit_c      = 1'b0;
    food_hit_c = 1'b0;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      if (LW'(i) < limit_c && seg[i] == {cand_x, cand_y}) hit_c = 1'b1;
      if (LW'(i) < len && seg[i] == lfsr[SW-1:0]) food_hit_c = 1'b1;
    end
    lose_c = oob | hit_c;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= S_INIT;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_INIT:  if (Ack) state_n = S_MOVE;
      S_MOVE:  if (Tick) state_n = S_CHECK;
      S_CHECK: state_n = lose_c ? S_LOSE : (grow_c ? S_EAT : S_MOVE);
      S_EAT:   if (win_c) state_n = S_WIN;
               else if (!food_hit_c) state_n = S_MOVE;
      S_WIN,
      S_LOSE:  if (Ack) state_n = S_INIT;
      default: state_n = S_INIT;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < int'(MAX_LEN); i++) seg[i] <= HOME;
      len    <= LW'(1);
      dir    <= DIR_R;
      pend   <= DIR_R;
      food_x <= FOOD_X0;
      food_y <= HOME_Y;
      cand_x <= HOME_X;
      cand_y <= HOME_Y;
      oob    <= 1'b0;
      lfsr   <= SEED;
    end else begin
      lfsr <= {lfsr[14:0], lfsr_fb_c};
      if (btn_valid_c) pend <= btn_dir_c;
      case (state)
        S_MOVE: if (Tick) begin
          dir    <= pend;
          cand_x <= next_x_c;
          cand_y <= next_y_c;
          oob    <= next_oob_c;
        end
        S_CHECK: if (!lose_c) begin
          for (int i = int'(MAX_LEN) - 1; i > 0; i--) seg[i] <= seg[i-1];
          seg[0] <= {cand_x, cand_y};
          if (grow_c && len < LW'(MAX_LEN)) len <= len + LW'(1);
        end
        S_EAT: if (!win_c && !food_hit_c) {food_x, food_y} <= lfsr[SW-1:0];
        S_WIN, S_LOSE: if (Ack) begin
          for (int i = 0; i < int'(MAX_LEN); i++) seg[i] <= HOME;
          len    <= LW'(1);
          dir    <= DIR_R;
          pend   <= DIR_R;
          food_x <= FOOD_X0;
          food_y <= HOME_Y;
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < int'(MAX_LEN); g++) begin : g_flat
    assign Locations_Flat[g*SW +: SW] = seg[g];
  end

  assign Head_X = head_x_c;
  assign Head_Y = head_y_c;
  assign Food_X = food_x;
  assign Food_Y = food_y;
  assign Length = len;
  assign Qi     = (state == S_INIT);
  assign Qm     = (state == S_MOVE);
  assign Qc     = (state == S_CHECK);
  assign Qe     = (state == S_EAT);
  assign Qw     = (state == S_WIN);
  assign Ql     = (state == S_LOSE);

endmodule

// File: tb/tb_snake_engine_gen.sv
// Directed bench for snake_engine_gen: default, wrapping and MAX_LEN=2 instances
// share one stimulus stream.
module tb_snake_engine_gen;

  logic clk, rst, tick, up, down, left, right, ack;

  logic [3:0]   d_hx, d_hy, d_fx, d_fy, w_hx, w_hy, w_fx, w_fy, s_hx, s_hy, s_fx, s_fy;
  logic [4:0]   d_len, w_len;
  logic [1:0]   s_len;
  logic [127:0] d_loc, w_loc;
  logic [15:0]  s_loc;
  logic d_qi, d_qm, d_qc, d_qe, d_qw, d_ql;
  logic w_qi, w_qm, w_qc, w_qe, w_qw, w_ql;
  logic s_qi, s_qm, s_qc, s_qe, s_qw, s_ql;

  int n_chk  = 0;
  int n_pass = 0;
  int cur_dir = 0;  // 0 R, 1 L, 2 U, 3 D

  snake_engine_gen u_dut (
    .Clk(clk), .Reset(rst), .Tick(tick), .Left(left), .Right(right), .Up(up), .Down(down),
    .Ack(ack), .Head_X(d_hx), .Head_Y(d_hy), .Food_X(d_fx), .Food_Y(d_fy), .Length(d_len),
    .Locations_Flat(d_loc), .Qi(d_qi), .Qm(d_qm), .Qc(d_qc), .Qe(d_qe), .Qw(d_qw), .Ql(d_ql)
  );

  snake_engine_gen #(.WRAP(1)) u_wrap (
    .Clk(clk), .Reset(rst), .Tick(tick), .Left(left), .Right(right), .Up(up), .Down(down),
    .Ack(ack), .Head_X(w_hx), .Head_Y(w_hy), .Food_X(w_fx), .Food_Y(w_fy), .Length(w_len),
    .Locations_Flat(w_loc), .Qi(w_qi), .Qm(w_qm), .Qc(w_qc), .Qe(w_qe), .Qw(w_qw), .Ql(w_ql)
  );

  snake_engine_gen #(.MAX_LEN(2)) u_small (
    .Clk(clk), .Reset(rst), .Tick(tick), .Left(left), .Right(right), .Up(up), .Down(down),
    .Ack(ack), .Head_X(s_hx), .Head_Y(s_hy), .Food_X(s_fx), .Food_Y(s_fy), .Length(s_len),
    .Locations_Flat(s_loc), .Qi(s_qi), .Qm(s_qm), .Qc(s_qc), .Qe(s_qe), .Qw(s_qw), .Ql(s_ql)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h want %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic u, input logic dn, input logic l, input logic r);
    up = u; down = dn; left = l; right = r;
    step();
    up = 0; down = 0; left = 0; right = 0;
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  // Tick strobe: one cycle to CHECK, one more to the post-CHECK state.
  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
  endtask

  task automatic wait_settle();
    int n = 0;
    while (!(d_qm || d_ql || d_qw) && n < 64) begin
      step();
      n++;
    end
    chk("settle", 32'(d_qm | d_ql | d_qw), 1);
  endtask

  task automatic move_dir(input int d);
    case (d)
      0:       press(0, 0, 0, 1);
      1:       press(0, 0, 1, 0);
      2:       press(1, 0, 0, 0);
      default: press(0, 1, 0, 0);
    endcase
    do_tick();
    wait_settle();
    cur_dir = d;
  endtask

  // Greedy step toward (tx,ty), avoiding walls, reversal and the body.
  task automatic seek(input int tx, input int ty);
    int hx, hy, len, best, bs, nx, ny, sc;
    logic blk;
    hx = int'(d_hx); hy = int'(d_hy); len = int'(d_len);
    best = cur_dir; bs = 1 << 30;
    for (int d = 0; d < 4; d++) begin
      if (len > 1 && d == (cur_dir ^ 1)) continue;
      nx = hx + ((d == 0) ? 1 : (d == 1) ? -1 : 0);
      ny = hy + ((d == 3) ? 1 : (d == 2) ? -1 : 0);
      if (nx < 0 || nx > 15 || ny < 0 || ny > 15) continue;
      blk = 1'b0;
      for (int i = 0; i < len; i++)
        if (d_loc[i*8+4 +: 4] == 4'(nx) && d_loc[i*8 +: 4] == 4'(ny)) blk = 1'b1;
      if (blk) continue;
      sc = ((nx > tx) ? nx - tx : tx - nx) + ((ny > ty) ? ny - ty : ty - ny);
      if (sc < bs) begin bs = sc; best = d; end
    end
    move_dir(best);
  endtask

  initial begin
    logic [7:0] saved_head;
    logic [4:0] saved_len;
    rst = 1; tick = 0; up = 0; down = 0; left = 0; right = 0; ack = 0;
    repeat (2) step();
    rst = 0;
    step();

    // Reset values, and Tick ignored in INIT
    chk("rst_state", {d_qi, d_qm, d_qc, d_qe, d_qw, d_ql}, 6'b100000);
    chk("rst_len", d_len, 1);
    chk("rst_head", {d_hx, d_hy}, 8'h88);
    chk("rst_food", {d_fx, d_fy}, 8'hA8);
    do_tick();
    chk("init_tick_state", {d_qi, d_qm, d_qc, d_qe, d_qw, d_ql}, 6'b100000);
    chk("init_tick_head", {d_hx, d_hy}, 8'h88);

    // Start, two moves right, eat at (10,8)
    pulse_ack();
    chk("ack_move", d_qm, 1);
    do_tick();
    chk("move1_head", {d_hx, d_hy}, 8'h98);
    chk("move1_len", d_len, 1);
    chk("move1_qm", d_qm, 1);
    do_tick();
    chk("move2_head", {d_hx, d_hy}, 8'hA8);
    chk("move2_len", d_len, 2);
    chk("move2_qe", d_qe, 1);
    chk("move2_seg1", d_loc[15:8], 8'h98);
    wait_settle();
    chk("eat_exit_qm", d_qm, 1);
    chk("food_off_body", 32'({d_fx, d_fy} != 8'hA8 && {d_fx, d_fy} != 8'h98), 1);
    chk("small_win", s_qw, 1);
    chk("small_len", s_len, 2);

    // Ack: small instance restarts, main instance ignores it in MOVE
    pulse_ack();
    chk("small_init", s_qi, 1);
    chk("small_init_len", s_len, 1);
    chk("small_init_head", {s_hx, s_hy}, 8'h88);
    chk("ack_ignored_move", d_qm, 1);
    chk("ack_ignored_head", {d_hx, d_hy}, 8'hA8);

    // Reversal discarded, then Up beats Left
    cur_dir = 0;
    press(0, 0, 1, 0);
    do_tick();
    wait_settle();
    chk("reverse_ignored", {d_hx, d_hy}, 8'hB8);
    press(1, 0, 1, 0);
    do_tick();
    wait_settle();
    cur_dir = 2;
    chk("up_over_left", {d_hx, d_hy}, 8'hB7);

    // Grow to 5 segments, then curl into the body
    for (int k = 0; k < 400 && d_len < 5 && !d_ql; k++) seek(int'(d_fx), int'(d_fy));
    chk("grow_to_5", 32'(d_len >= 5), 1);
    for (int k = 0; k < 100 && {d_hx, d_hy} != 8'h22 && !d_ql; k++) seek(2, 2);
    chk("reach_2_2", {d_hx, d_hy}, 8'h22);
    if (cur_dir == 1) move_dir(2);
    repeat (5) move_dir(0);
    move_dir(3);
    move_dir(1);
    chk("pre_collide_qm", d_qm, 1);
    saved_head = {d_hx, d_hy};
    saved_len  = d_len;
    move_dir(2);
    chk("self_hit_ql", d_ql, 1);
    chk("self_hit_head", {d_hx, d_hy}, 32'(saved_head));
    chk("self_hit_len", d_len, 32'(saved_len));
    pulse_ack();
    chk("restart_state", {d_qi, d_qm, d_qc, d_qe, d_qw, d_ql}, 6'b100000);
    chk("restart_len", d_len, 1);
    chk("restart_head", {d_hx, d_hy}, 8'h88);
    chk("restart_food", {d_fx, d_fy}, 8'hA8);

    // Wall vs wrap: up one row, then right to the edge and beyond
    rst = 1; step(); rst = 0; step();
    pulse_ack();
    press(1, 0, 0, 0);
    do_tick();
    chk("wall_up", {d_hx, d_hy}, 8'h87);
    press(0, 0, 0, 1);
    repeat (7) do_tick();
    chk("wall_edge_head", {d_hx, d_hy}, 8'hF7);
    chk("wall_edge_qm", d_qm, 1);
    chk("wrap_edge_head", {w_hx, w_hy}, 8'hF7);
    do_tick();
    chk("wall_ql", d_ql, 1);
    chk("wall_hx", d_hx, 15);
    chk("wrap_hx", w_hx, 0);
    chk("wrap_qm", w_qm, 1);

    // Reset asserted while in EAT takes effect immediately
    rst = 1; step(); rst = 0; step();
    pulse_ack();
    do_tick();
    tick = 1'b1; step(); tick = 1'b0; step();
    chk("pre_reset_qe", d_qe, 1);
    #2 rst = 1;
    #1;
    chk("async_state", {d_qi, d_qm, d_qc, d_qe, d_qw, d_ql}, 6'b100000);
    chk("async_len", d_len, 1);
    chk("async_head", {d_hx, d_hy}, 8'h88);
    chk("async_food", {d_fx, d_fy}, 8'hA8);
    step();
    rst = 0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
